// File: rtl/dc_bitstream_packer_if.sv
// Codeword input and packed-word output bundle of the DC bitstream packer.
// The packer takes the slave view; the codeword source / word sink takes master.
interface dc_bitstream_packer_if #(
    parameter int MAX_CODE_LEN = 24,
    parameter int WORD_W       = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic [MAX_CODE_LEN-1:0] code_value;
    logic [5:0]              code_length;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [WORD_W-1:0]       out_data;
    logic [2:0]              out_bytes;
    logic                    out_last;

    modport master (
        output in_valid, code_value, code_length, flush, out_ready,
        input  in_ready, out_valid, out_data, out_bytes, out_last
    );

    modport slave (
        input  in_valid, code_value, code_length, flush, out_ready,
        output in_ready, out_valid, out_data, out_bytes, out_last
    );
endinterface

// File: rtl/dc_bitstream_packer.sv
// Packs right-aligned variable-length codewords MSB-first into 32-bit words;
// a flush emits the zero-padded tail as the final word of the slice.
module dc_bitstream_packer #(
    parameter int MAX_CODE_LEN = 24,
    parameter int WORD_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    dc_bitstream_packer_if.slave   bus,
    output logic [31:0]            total_bits,
    output logic                   err_len
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_LAST     = 2'd2,
        ST_WAIT_ACK = 2'd3
    } state_e;

    function automatic logic [4:0] clamp_len(input logic [5:0] len_in);
        logic [4:0] len_out;
        if (len_in > 6'd24) begin
            len_out = 5'd24;
        end else begin
            len_out = len_in[4:0];
        end
        return len_out;
    endfunction

    function automatic logic [23:0] mask_code(input logic [23:0] value, input logic [4:0] len);
        return value & ~(24'hFF_FFFF << len);
    endfunction

    state_e      state_q,     state_d;
    logic [55:0] acc_q,       acc_d;
    logic [5:0]  fill_q,      fill_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q,  out_data_d;
    logic [2:0]  out_bytes_q, out_bytes_d;
    logic        out_last_q,  out_last_d;
    logic [31:0] total_q,     total_d;
    logic        err_q,       err_d;

    logic        out_free_s;
    logic        drain_now_s;
    logic        in_ready_s;
    logic        accept_s;
    logic [4:0]  len_s;
    logic [55:0] acc_base_s;
    logic [5:0]  fill_base_s;
    logic [5:0]  shift_s;
    logic [55:0] code_bits_s;
    logic [2:0]  tail_bytes_s;

    assign out_free_s   = !out_valid_q || bus.out_ready;
    assign drain_now_s  = (fill_q >= 6'd32) && out_free_s;
    assign in_ready_s   = (state_q == ST_RUN) && ((fill_q < 6'd32) || drain_now_s);
    assign accept_s     = bus.in_valid && in_ready_s;
    assign len_s        = clamp_len(bus.code_length);
    // New bits always land after the drain shift so a same-cycle accept never collides.
    assign acc_base_s   = drain_now_s ? {acc_q[23:0], 32'd0} : acc_q;
    assign fill_base_s  = drain_now_s ? (fill_q - 6'd32) : fill_q;
    assign shift_s      = 6'd56 - fill_base_s - {1'b0, len_s};
    assign code_bits_s  = {32'd0, mask_code(bus.code_value, len_s)} << shift_s;
    assign tail_bytes_s = {1'b0, fill_q[4:3]} + {2'b00, |fill_q[2:0]};

    // Next-state, accumulator and output-register logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_bytes_d = out_bytes_q;
        out_last_d  = out_last_q;
        total_d     = total_q;
        err_d       = err_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (drain_now_s) begin
            out_data_d  = acc_q[55:24];
            out_bytes_d = 3'd4;
            out_last_d  = 1'b0;
            out_valid_d = 1'b1;
        end else begin
            out_data_d  = out_data_q;
        end

        if (accept_s) begin
            acc_d   = acc_base_s | code_bits_s;
            fill_d  = fill_base_s + {1'b0, len_s};
            total_d = total_q + {27'd0, len_s};
            if (bus.code_length > 6'd24) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end else begin
            acc_d  = acc_base_s;
            fill_d = fill_base_s;
        end

        case (state_q)
            ST_RUN: begin
                if (bus.flush) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if ((fill_q < 6'd32) && out_free_s) begin
                    state_d = ST_LAST;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_LAST: begin
                out_data_d  = acc_q[55:24];
                out_bytes_d = tail_bytes_s;
                out_last_d  = 1'b1;
                out_valid_d = 1'b1;
                acc_d       = 56'd0;
                fill_d      = 6'd0;
                state_d     = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    total_d     = 32'd0;
                    state_d     = ST_RUN;
                end else begin
                    state_d     = ST_WAIT_ACK;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and output registers; reset drops out_valid without a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            acc_q       <= 56'd0;
            fill_q      <= 6'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_bytes_q <= 3'd0;
            out_last_q  <= 1'b0;
            total_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_bytes_q <= out_bytes_d;
            out_last_q  <= out_last_d;
            total_q     <= total_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_bytes = out_bytes_q;
    assign bus.out_last  = out_last_q;
    assign total_bits    = total_q;
    assign err_len       = err_q;

endmodule
